// File: rtl/sync_word_capture.sv
// Captures a synchronized word once it has been stable for stable_cycles extra edges
// and differs from the last captured word, then queues it in a small FIFO.
module sync_word_capture #(
    parameter int data_bus_size = 24,
    parameter int stable_cycles = 2,
    parameter int fifo_depth    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [data_bus_size-1:0]      in_data_sync,
    output logic [data_bus_size-1:0]      out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(fifo_depth):0]   fill_level,
    output logic                          overflow
);

    localparam int             PW       = $clog2(fifo_depth);
    localparam logic [3:0]     STABLE   = 4'(stable_cycles);
    localparam logic [PW:0]    DEPTH    = (PW+1)'(fifo_depth);
    localparam logic [PW-1:0]  PTR_ONE  = 1;
    localparam logic [PW:0]    FILL_ONE = 1;

    logic [data_bus_size-1:0] cand;
    logic [data_bus_size-1:0] last;
    logic [3:0]               cnt;
    logic [data_bus_size-1:0] mem [fifo_depth];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;

    logic same;
    logic capture;
    logic pop;
    logic full;
    logic push;

    always_comb begin
        same    = (in_data_sync == cand);
        capture = same && (cnt == STABLE - 4'd1) && (cand != last);
        pop     = out_valid && out_ready;
        full    = (fill_level == DEPTH);
        push    = capture && (!full || pop);
    end

    assign out_valid = (fill_level != '0);
    assign out_data  = mem[rd_ptr];

    // Storage is not reset; contents are only visible through out_valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= cand;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand       <= '0;
            cnt        <= STABLE;
            last       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (!same) begin
                cand <= in_data_sync;
                cnt  <= 4'd0;
            end else if (cnt < STABLE) begin
                cnt <= cnt + 4'd1;
            end

            // A dropped word still updates last so it is not re-captured later.
            if (capture) begin
                last <= cand;
            end
            if (capture && full && !pop) begin
                overflow <= 1'b1;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            case ({push, pop})
                2'b10:   fill_level <= fill_level + FILL_ONE;
                2'b01:   fill_level <= fill_level - FILL_ONE;
                default: fill_level <= fill_level;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_word_capture.sv
// Scoreboard bench for sync_word_capture: a driver feeds directed and random words
// through a run-length reference model; a negedge monitor checks every output transfer.
module tb_sync_word_capture;

    localparam int W      = 24;
    localparam int STABLE = 2;
    localparam int DEPTH  = 4;

    logic          clk;
    logic          reset;
    logic [W-1:0]  in_data_sync;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    fill_level;
    logic          overflow;

    sync_word_capture #(
        .data_bus_size (W),
        .stable_cycles (STABLE),
        .fifo_depth    (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data_sync (in_data_sync),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fill_level   (fill_level),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int n_xfer = 0;

    // Reference model: a word is captured once it has been seen on STABLE+1
    // consecutive edges and differs from the previously captured word.
    logic [W-1:0] sb_q[$];
    logic [W-1:0] m_prev;
    logic [W-1:0] m_last;
    int           m_run;
    int           m_fill;
    logic         m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_edge(input logic [W-1:0] d, input logic rdy, input logic rst);
        bit pop;
        if (rst) begin
            sb_q.delete();
            m_prev = '0;
            m_last = '0;
            m_run  = STABLE + 1;
            m_fill = 0;
            m_ovf  = 1'b0;
        end else begin
            pop = rdy && (m_fill > 0);
            if (d == m_prev) begin
                if (m_run <= STABLE) m_run++;
            end else begin
                m_run = 0;
            end
            m_prev = d;
            if (m_run == STABLE && d != m_last) begin
                m_last = d;
                if (m_fill < DEPTH || pop) begin
                    sb_q.push_back(d);
                    m_fill++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (pop) m_fill--;
        end
    endtask

    task automatic step(input logic [W-1:0] d, input logic rdy, input logic rst);
        in_data_sync = d;
        out_ready    = rdy;
        reset        = rst;
        @(posedge clk);
        model_edge(d, rdy, rst);
        #1;
    endtask

    task automatic hold(input logic [W-1:0] d, input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(d, rdy, 1'b0);
    endtask

    task automatic do_reset();
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
    endtask

    // Monitor: state checks every cycle, data check whenever a transfer is about to occur.
    bit mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("fill_level", 32'(fill_level), 32'(m_fill));
            chk("out_valid", 32'(out_valid), 32'(m_fill > 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (out_valid && out_ready) begin
                n_xfer++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_transfer", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("out_data", 32'(out_data), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int x0;
        in_data_sync = '0;
        out_ready    = 1'b0;
        reset        = 1'b1;
        m_prev = '0; m_last = '0; m_run = STABLE + 1; m_fill = 0; m_ovf = 1'b0;
        do_reset();
        mon_en = 1'b1;

        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_fill", 32'(fill_level), 32'd0);
        chk("reset_ovf", 32'(overflow), 32'd0);

        // Basic capture latency: value appears after the third edge.
        hold(24'h00A5A5, 1'b0, 2);
        chk("latency_not_yet", 32'(out_valid), 32'd0);
        hold(24'h00A5A5, 1'b0, 1);
        chk("cap_valid", 32'(out_valid), 32'd1);
        chk("cap_data", 32'(out_data), 32'h00A5A5);
        chk("cap_fill", 32'(fill_level), 32'd1);

        // One-edge glitch is discarded.
        do_reset();
        step(24'h000011, 1'b0, 1'b0);
        hold(24'h000022, 1'b0, 4);
        chk("glitch_fill", 32'(fill_level), 32'd1);
        chk("glitch_data", 32'(out_data), 32'h000022);

        // Overflow on the fifth capture, then drain 1..4 in order.
        do_reset();
        for (int v = 1; v <= 5; v++) hold(24'(v), 1'b0, 3);
        chk("ovf_fill", 32'(fill_level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_head", 32'(out_data), 32'd1);
        hold(24'd5, 1'b1, 4);
        chk("drain_fill", 32'(fill_level), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Capture into a full FIFO while popping: no drop.
        do_reset();
        for (int v = 1; v <= 4; v++) hold(24'(v), 1'b0, 3);
        step(24'd6, 1'b0, 1'b0);
        step(24'd6, 1'b0, 1'b0);
        step(24'd6, 1'b1, 1'b0);
        chk("fullpop_fill", 32'(fill_level), 32'd4);
        chk("fullpop_ovf", 32'(overflow), 32'd0);
        chk("fullpop_head", 32'(out_data), 32'd2);
        hold(24'd6, 1'b1, 5);
        chk("fullpop_drained", 32'(fill_level), 32'd0);

        // Long hold transfers once; A-B-A transfers three times.
        do_reset();
        x0 = n_xfer;
        hold(24'd7, 1'b1, 20);
        chk("hold_once", 32'(n_xfer - x0), 32'd1);
        x0 = n_xfer;
        hold(24'd7, 1'b0, 2);
        step(24'd8, 1'b1, 1'b0);
        x0 = n_xfer;
        do_reset();
        hold(24'd7, 1'b1, 4);
        hold(24'd8, 1'b1, 4);
        hold(24'd7, 1'b1, 4);
        chk("aba_three", 32'(n_xfer - x0), 32'd3);

        // Mid-operation reset empties the FIFO; held zero is never captured.
        do_reset();
        for (int v = 1; v <= 3; v++) hold(24'(v), 1'b0, 3);
        chk("pre_rst_fill", 32'(fill_level), 32'd3);
        step(24'd3, 1'b0, 1'b1);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        hold('0, 1'b1, 6);
        chk("zero_not_cap", 32'(fill_level), 32'd0);

        // Random phase: few distinct values, random hold lengths, ready and resets.
        for (int i = 0; i < 800; i++) begin
            logic [W-1:0] v;
            int len;
            v   = 24'($urandom_range(0, 5)) * 24'h010101;
            len = $urandom_range(1, 4);
            if ($urandom_range(0, 99) == 0) begin
                step(v, 1'b0, 1'b1);
            end else begin
                for (int k = 0; k < len; k++) step(v, ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1, 1'b0);
            end
        end

        hold(24'h123456, 1'b1, 4 + 2 * DEPTH);
        chk("final_drain", 32'(fill_level), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sync_word_capture.md
SYNC_WORD_CAPTURE -- requirements
Module: sync_word_capture

Interface
REQ-001 Parameter data_bus_size, default 24, width of captured data word.
REQ-002 Parameter stable_cycles, default 2, range 1..15; extra edges a new value must hold before capture.
REQ-003 Parameter fifo_depth, default 4, power of two, 2..16; capture FIFO entries.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data_sync  input  data_bus_size  word from the fast-to-slow synchronizer, already in the clk domain; may change on any edge.
REQ-007 out_data  output  data_bus_size  FIFO head word.
REQ-008 out_valid  output  1  FIFO non-empty; out_data is valid.
REQ-009 out_ready  input  1  consumer accepts head word.
REQ-010 fill_level  output  $clog2(fifo_depth)+1  current FIFO occupancy.
REQ-011 overflow  output  1  sticky flag: a captured word was dropped.

Function
REQ-012 Internal state: candidate register cand, stability counter cnt (saturates at stable_cycles), last-captured register last, FIFO storage, read/write pointers, occupancy count.
REQ-013 Each edge: if in_data_sync != cand, then cand <= in_data_sync and cnt <= 0.
REQ-014 Each edge: if in_data_sync == cand and cnt < stable_cycles, then cnt <= cnt+1.
REQ-015 Capture event: the edge where in_data_sync == cand, cnt == stable_cycles-1 and cand != last; at that edge last <= cand.
REQ-016 Timing: a value first sampled at edge t and unchanged through edge t+stable_cycles is captured at edge t+stable_cycles; out_valid rises after that edge if the FIFO was empty (no bypass).
REQ-017 A value that changes before its capture edge is discarded; cnt restarts for the new value.
REQ-018 A value equal to last is never re-captured, however long it is held.
REQ-019 Pop: out_valid && out_ready at an edge removes the head; the next word appears on out_data after that edge.
REQ-020 out_data and out_valid are held stable while out_valid && !out_ready.
REQ-021 Capture with fill_level < fifo_depth: word written at tail, fill_level +1.
REQ-022 Capture with FIFO full and no pop at the same edge: word dropped, overflow <= 1, last still updated, FIFO contents unchanged.
REQ-023 Capture with FIFO full and pop at the same edge: both occur, fill_level unchanged, no overflow.
REQ-024 Capture and pop at the same edge with FIFO non-full: both occur, fill_level unchanged.
REQ-025 out_ready while FIFO empty has no effect; fill_level never underflows.
REQ-026 Pointers wrap modulo fifo_depth; FIFO order is preserved across wrap.
REQ-027 overflow clears only on reset.

Reset
REQ-028 While reset is high at an edge: cand <= 0, cnt <= stable_cycles, last <= 0, pointers <= 0, fill_level <= 0, overflow <= 0.
REQ-029 After reset: out_valid = 0, out_data undefined-but-ignored, no capture during the reset edge.
REQ-030 Reset asserted mid-operation discards all FIFO contents and any pending candidate at that edge; the input held as 0 after reset is never captured.
REQ-031 The first nonzero stable value after reset is captured per REQ-016.

Verification (stable_cycles=2, fifo_depth=4)
REQ-032 Reset, then in_data_sync=0x00A5A5 from edge t, out_ready=0 -> capture at edge t+2, out_valid=1, out_data=0x00A5A5, fill_level=1.
REQ-033 Glitch: in_data_sync=0x000011 for one edge, then 0x000022 held -> only 0x000022 captured, fill_level=1.
REQ-034 Capture 0x1, 0x2, 0x3, 0x4, 0x5 (each held 3 edges) with out_ready=0 -> fill_level=4, overflow=1, pops return 0x1..0x4 in order.
REQ-035 FIFO full; at the edge capturing 0x6, out_ready=1 -> fill_level stays 4, overflow stays 0, head becomes the second-oldest word.
REQ-036 Hold 0x7 for 20 edges, out_ready=1 -> exactly one transfer of 0x7; 0x7 -> 0x8 -> 0x7 produces three transfers.
REQ-037 Reset asserted with fill_level=3 -> next edge fill_level=0, out_valid=0, overflow=0.
